// File: rtl/if_stage_unit.sv
// Fetch stage: owns the PC driving instruction memory and the IF/ID pipeline register.
// Sequences the post-reset boot window, sequential fetch, stall, redirect and end of program.
module if_stage_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH  = 50,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic [31:0] instr_in_i,
  output logic [31:0] addr_pc_o,
  output logic [31:0] instr_id_o,
  output logic [31:0] pc_id_o,
  output logic [31:0] pc_plus4_id_o,
  output logic        valid_id_o,
  output logic        redirect_o,
  output logic        fetch_done_o
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0]  BootLast = 4'(BOOT_CYCLES - 1);
  localparam logic [31:0] DepthW   = 32'(IMEM_DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
  logic        valid_id_q, valid_id_d;
  logic        redirect_q, redirect_d;

  logic        redir_req;
  logic [31:0] redir_pc;
  logic        out_of_range;
  logic        unused_target_bits;

  // Branch resolves in EX and is older than the jump in ID, so it wins.
  assign redir_req    = branch_taken_i | jump_i;
  assign redir_pc     = branch_taken_i ? {branch_target_i[31:2], 2'b00}
                                       : {pc_plus4_id_q[31:28], jump_index_i, 2'b00};
  assign out_of_range = ({2'b00, pc_q[31:2]} >= DepthW);

  assign unused_target_bits = ^branch_target_i[1:0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_d          = pc_q;
    instr_id_d    = instr_id_q;
    pc_id_d       = pc_id_q;
    pc_plus4_id_d = pc_plus4_id_q;
    valid_id_d    = valid_id_q;
    redirect_d    = 1'b0;

    unique case (state_q)
      StBoot: begin
        valid_id_d = 1'b0;
        instr_id_d = '0;
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == BootLast) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (redir_req) begin
          pc_d       = redir_pc;
          valid_id_d = 1'b0;
          instr_id_d = '0;
          redirect_d = 1'b1;
        end else if (stall_i) begin
          // Hold PC and IF/ID.
        end else if (out_of_range) begin
          valid_id_d = 1'b0;
          instr_id_d = '0;
          state_d    = StDone;
        end else begin
          instr_id_d    = instr_in_i;
          pc_id_d       = pc_q;
          pc_plus4_id_d = pc_q + 32'd4;
          valid_id_d    = 1'b1;
          pc_d          = pc_q + 32'd4;
        end
      end

      StDone: begin
        valid_id_d = 1'b0;
        instr_id_d = '0;
        if (redir_req) begin
          pc_d       = redir_pc;
          redirect_d = 1'b1;
          state_d    = StRun;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StBoot;
      cnt_q         <= '0;
      pc_q          <= RESET_PC;
      instr_id_q    <= '0;
      pc_id_q       <= '0;
      pc_plus4_id_q <= '0;
      valid_id_q    <= 1'b0;
      redirect_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_q          <= pc_d;
      instr_id_q    <= instr_id_d;
      pc_id_q       <= pc_id_d;
      pc_plus4_id_q <= pc_plus4_id_d;
      valid_id_q    <= valid_id_d;
      redirect_q    <= redirect_d;
    end
  end

  assign addr_pc_o     = pc_q;
  assign instr_id_o    = instr_id_q;
  assign pc_id_o       = pc_id_q;
  assign pc_plus4_id_o = pc_plus4_id_q;
  assign valid_id_o    = valid_id_q;
  assign redirect_o    = redirect_q;
  assign fetch_done_o  = (state_q == StDone);

endmodule

// File: doc/if_stage_unit.md
Name: if_stage_unit

Overview:
- Fetch stage of the 5-stage MIPS pipeline: owns the PC register that drives instruction_memory addr_pc, and the IF/ID pipeline register that captures the fetched instruction for decode.
- Handles the post-reset boot window for memory loading, next-PC selection, stall, flush/redirect, and end-of-program detection.
- Sits between the hazard/branch logic (ID/EX) and instruction_memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_DEPTH, 50, instruction memory depth in words; fetches at word index >= IMEM_DEPTH are out of range.
BOOT_CYCLES, 2, cycles held in BOOT after reset release (memory load window); legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
stall  in  1  hazard-unit hold; freezes the PC and IF/ID.
branch_taken  in  1  branch resolved taken in EX.
branch_target  in  32  branch destination; bits [1:0] ignored (forced 00).
jump  in  1  J-type in ID.
jump_index  in  26  address field of the instruction in ID.
instr_in  in  32  {op,rs,rt,rd,sa,func} from instruction_memory for the current addr_pc.
addr_pc  out  32  fetch address to instruction_memory.
instr_id  out  32  IF/ID instruction.
pc_id  out  32  IF/ID PC of instr_id.
pc_plus4_id  out  32  IF/ID PC+4.
valid_id  out  1  IF/ID holds a real instruction.
redirect  out  1  one-cycle pulse when a branch or jump redirect is taken (ID/EX flush request).
fetch_done  out  1  high while in the DONE state.

Behaviour:
Reset:
- rst=0, asynchronous: addr_pc=RESET_PC; instr_id, pc_id and pc_plus4_id = 0; valid_id=0; redirect=0; fetch_done=0; state=BOOT; boot counter=0.
- Reset asserted mid-operation aborts everything immediately, with the same values.

States: BOOT, RUN, DONE.

BOOT:
- addr_pc is held.
- IF/ID holds bubbles (valid_id=0, instr_id=0).
- stall and redirect inputs are ignored.
- Counter increments each cycle. After exactly BOOT_CYCLES rising edges past reset release, the state moves to RUN.
- The first real capture occurs on the first RUN edge.

RUN: each edge applies the first matching rule, in this priority order.
1. branch_taken:
   - addr_pc <= {branch_target[31:2],2'b00}.
   - IF/ID <= bubble.
   - redirect <= 1.
2. jump:
   - addr_pc <= {pc_plus4_id[31:28], jump_index, 2'b00}.
   - IF/ID <= bubble.
   - redirect <= 1.
3. stall:
   - addr_pc and IF/ID hold.
   - redirect <= 0.
4. addr_pc[31:2] >= IMEM_DEPTH:
   - IF/ID <= bubble.
   - addr_pc holds.
   - state <= DONE.
5. Otherwise:
   - instr_id <= instr_in; pc_id <= addr_pc; pc_plus4_id <= addr_pc+4; valid_id <= 1.
   - addr_pc <= addr_pc+4 (mod 2^32 wrap, no flag).

Redirect rules:
- Redirect overrides stall.
- branch_taken and jump in the same cycle: the branch wins (older instruction), and the jump is discarded.
- redirect is high for exactly one cycle per redirect. Back-to-back redirects keep it high.

DONE:
- fetch_done=1; IF/ID is a bubble every cycle; addr_pc holds.
- branch_taken or jump (same priority and target rules as RUN) loads the new PC, pulses redirect, and returns to RUN.
- If the new target is still out of range, the unit re-enters DONE on the next RUN edge.

General:
- All state updates happen on the rising clk edge.
- Fetch latency is one cycle: the instruction presented at addr_pc in cycle N appears on instr_id in cycle N+1.

Test Plan:
- Reset and boot: hold rst=0 for 3 cycles, then release with BOOT_CYCLES=2 -> addr_pc=0 for 2 edges with valid_id=0; on the 3rd edge instr_id=mem[0], pc_id=0, pc_plus4_id=4, and addr_pc=4.
- Sequential run with stall: run to addr_pc=0x10, raise stall for 2 cycles -> addr_pc stays 0x10 and instr_id stays mem[3]. On release, the next edge gives instr_id=mem[4] and addr_pc=0x14.
- Branch flush: at addr_pc=0x18 assert branch_taken with branch_target=0x0000_0007 -> addr_pc=0x4 next edge, valid_id=0, instr_id=0, redirect=1 for one cycle; the following edge gives instr_id=mem[1].
- Jump with simultaneous branch: pc_plus4_id=0x1000_0008, jump=1, jump_index=0x000_0003 alone -> addr_pc=0x1000_000C. Repeat with branch_taken=1 and branch_target=0x20 -> addr_pc=0x20.
- End of program: IMEM_DEPTH=4, no redirects -> after capturing mem[3], addr_pc=0x10 gives a bubble and fetch_done=1, held. Then branch_taken with target 0x8 -> redirect=1, fetch_done=0, and the next capture is mem[2].
- Async reset mid-run: drop rst between edges while valid_id=1 at addr_pc=0x14 -> all outputs go to reset values immediately without waiting for a clock edge, and the boot sequence restarts.
